// File: rtl/lane_op_requester.sv
// lane_op_requester: per-lane operand requester.
// Converts one accepted operand request into streams of VRF word read
// requests, one independent read channel per operand queue (ALUA, ALUB,
// StoreOp), each with its own request/grant handshake toward the bank arbiter.
// op_req_i packing (MSB..LSB): {vs1, vs2, queue_req[NrOpQueue-1:0], vlB}.
module lane_op_requester #(
   parameter  int unsigned NrOpQueue        = 3,
   parameter  int unsigned ByteBlockWidth   = 4,
   parameter  int unsigned RegSliceNumWords = 8,
   parameter  int unsigned NrVReg           = 32,
   parameter  int unsigned VlenWidth        = 16,
   localparam int unsigned VRegIdxWidth     = $clog2(NrVReg),
   localparam int unsigned SliceOffWidth    = $clog2(RegSliceNumWords),
   localparam int unsigned AddrWidth        = VRegIdxWidth + SliceOffWidth,
   localparam int unsigned OpReqWidth       = 2*VRegIdxWidth + NrOpQueue + VlenWidth
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                op_req_valid_i,
   input  logic [OpReqWidth-1:0]               op_req_i,
   output logic                                op_req_ready_o,
   output logic [NrOpQueue-1:0]                rd_req_o,
   output logic [NrOpQueue-1:0][AddrWidth-1:0] rd_addr_o,
   input  logic [NrOpQueue-1:0]                rd_gnt_i,
   output logic                                op_done_o
);

   typedef logic [VlenWidth-1:0] vlen_t;
   typedef logic [VlenWidth:0]   vlen_ext_t;
   typedef logic [AddrWidth-1:0] vrf_addr_t;

   localparam int unsigned WordRound = (1 << ByteBlockWidth) - 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Request field decode
   logic [VlenWidth-1:0]    req_vlb;
   logic [NrOpQueue-1:0]    req_queue;
   logic [VRegIdxWidth-1:0] req_vs1;
   logic [VRegIdxWidth-1:0] req_vs2;

   assign req_vlb   = op_req_i[VlenWidth-1:0];
   assign req_queue = op_req_i[VlenWidth +: NrOpQueue];
   assign req_vs2   = op_req_i[VlenWidth+NrOpQueue +: VRegIdxWidth];
   assign req_vs1   = op_req_i[VlenWidth+NrOpQueue+VRegIdxWidth +: VRegIdxWidth];

   // Word count of the incoming request, rounded up to whole VRF words
   vlen_ext_t vlb_round;
   vlen_t     nwords_new;

   assign vlb_round  = {1'b0, req_vlb} + vlen_ext_t'(WordRound);
   assign nwords_new = vlen_t'(vlb_round >> ByteBlockWidth);

   state_e                      state_q, state_d;
   vlen_t                       nwords_q, nwords_d;
   logic [NrOpQueue-1:0]        req_q, req_d;
   logic [NrOpQueue-1:0][VlenWidth-1:0] cnt_q, cnt_d;
   logic [NrOpQueue-1:0][AddrWidth-1:0] addr_q, addr_d;
   logic                        done_q, done_d;

   // State, channel counters and registered handshake outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         nwords_q <= '0;
         req_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         nwords_q <= nwords_d;
         req_q    <= req_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         done_q   <= done_d;
      end
   end

   // Next-state: accept in IDLE, advance granted channels in BUSY.
   // The FSM returns to IDLE on the same edge that retires the last request,
   // so op_done_o and ready coincide and a follow-up op can be accepted then.
   always_comb begin
      state_d  = state_q;
      nwords_d = nwords_q;
      req_d    = req_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (op_req_valid_i) begin
               nwords_d = nwords_new;
               for (int unsigned q = 0; q < NrOpQueue; q++) begin
                  req_d[q]  = req_queue[q] && (nwords_new != '0);
                  cnt_d[q]  = '0;
                  addr_d[q] = vrf_addr_t'((q == 1) ? req_vs2 : req_vs1) << SliceOffWidth;
               end
               if (|req_d) state_d = BUSY;
               else        done_d  = 1'b1;
            end
         end
         BUSY: begin
            for (int unsigned q = 0; q < NrOpQueue; q++) begin
               if (req_q[q] && rd_gnt_i[q]) begin
                  cnt_d[q]  = cnt_q[q] + vlen_t'(1);
                  addr_d[q] = addr_q[q] + vrf_addr_t'(1);
                  if (cnt_q[q] == nwords_q - vlen_t'(1)) req_d[q] = 1'b0;
               end
            end
            if (!(|req_d)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   assign op_req_ready_o = (state_q == IDLE);
   assign rd_req_o       = req_q;
   assign rd_addr_o      = addr_q;
   assign op_done_o      = done_q;

endmodule

// File: tb/tb_lane_op_requester.sv
// Self-checking bench for lane_op_requester: directed scenarios plus random
// ops checked against a queue-per-channel model of expected read addresses.
module tb_lane_op_requester;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic              op_req_valid;
   logic [28:0]       op_req;
   logic              op_req_ready;
   logic [2:0]        rd_req;
   logic [2:0][7:0]   rd_addr;
   logic [2:0]        rd_gnt;
   logic              op_done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Expected outstanding read addresses per channel, in issue order
   int exp_q [3][$];

   always #5 clk = ~clk;

   lane_op_requester #(
      .NrOpQueue(3),
      .ByteBlockWidth(4),
      .RegSliceNumWords(8),
      .NrVReg(32),
      .VlenWidth(16)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .op_req_valid_i(op_req_valid),
      .op_req_i(op_req),
      .op_req_ready_o(op_req_ready),
      .rd_req_o(rd_req),
      .rd_addr_o(rd_addr),
      .rd_gnt_i(rd_gnt),
      .op_done_o(op_done)
   );

   function automatic logic [28:0] pack_req(input int vs1, input int vs2,
                                            input logic [2:0] qr, input int vlb);
      logic [4:0]  v1;
      logic [4:0]  v2;
      logic [15:0] l;
      v1 = 5'(vs1);
      v2 = 5'(vs2);
      l  = 16'(vlb);
      return {v1, v2, qr, l};
   endfunction

   // Model: each active queue reads ceil(vlB/16) words from vs*8 upward, mod 256
   task automatic load_model(input int vs1, input int vs2, input logic [2:0] qr, input int vlb);
      int nw;
      nw = (vlb + 15) / 16;
      for (int q = 0; q < 3; q++) begin
         exp_q[q].delete();
         if (qr[q])
            for (int i = 0; i < nw; i++)
               exp_q[q].push_back((((q == 1) ? vs2 : vs1) * 8 + i) % 256);
      end
   endtask

   task automatic start_op(input string name, input int vs1, input int vs2,
                           input logic [2:0] qr, input int vlb, input bit hold);
      @(negedge clk);
      total_cnt++;
      if (op_req_ready !== 1'b1) $display("FAIL %s ready_before_accept got=%b want=1", name, op_req_ready);
      else pass_cnt++;
      op_req_valid = 1'b1;
      op_req       = pack_req(vs1, vs2, qr, vlb);
      @(posedge clk);
      load_model(vs1, vs2, qr, vlb);
      #1;
      if (!hold) op_req_valid = 1'b0;
   endtask

   // Cycle-by-cycle comparison after an accept; cycle 1 is the cycle after accept
   task automatic run_checks(input string name, input int exp_done, input logic [2:0] rand_mask,
                             input int stall1);
      bit finished;
      bit all_empty;
      int done_at;
      finished = 1'b0;
      done_at  = -1;
      for (int c = 1; c <= 400 && !finished; c++) begin
         @(negedge clk);
         all_empty = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
         for (int q = 0; q < 3; q++) begin
            total_cnt++;
            if (rd_req[q] !== (exp_q[q].size() != 0))
               $display("FAIL %s req[%0d] cyc=%0d got=%b want=%b", name, q, c, rd_req[q], exp_q[q].size() != 0);
            else pass_cnt++;
            if (exp_q[q].size() != 0) begin
               total_cnt++;
               if (rd_addr[q] !== 8'(exp_q[q][0]))
                  $display("FAIL %s addr[%0d] cyc=%0d got=%0d want=%0d", name, q, c, rd_addr[q], exp_q[q][0]);
               else pass_cnt++;
            end
         end
         total_cnt++;
         if (op_done !== all_empty) $display("FAIL %s done cyc=%0d got=%b want=%b", name, c, op_done, all_empty);
         else pass_cnt++;
         total_cnt++;
         if (op_req_ready !== all_empty) $display("FAIL %s ready cyc=%0d got=%b want=%b", name, c, op_req_ready, all_empty);
         else pass_cnt++;
         if (all_empty) begin
            finished = 1'b1;
            done_at  = c;
         end else begin
            for (int q = 0; q < 3; q++)
               rd_gnt[q] = rand_mask[q] ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (c <= stall1) rd_gnt[1] = 1'b0;
            @(posedge clk);
            for (int q = 0; q < 3; q++)
               if (exp_q[q].size() != 0 && rd_gnt[q]) void'(exp_q[q].pop_front());
         end
      end
      if (!finished) begin
         total_cnt++;
         $display("FAIL %s timeout got=no_done want=done", name);
      end else if (exp_done > 0) begin
         total_cnt++;
         if (done_at != exp_done) $display("FAIL %s done_cycle got=%0d want=%0d", name, done_at, exp_done);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (op_req_ready !== 1'b1) $display("FAIL reset ready got=%b want=1", op_req_ready); else pass_cnt++;
      total_cnt++;
      if (rd_req !== 3'b000) $display("FAIL reset req got=%b want=000", rd_req); else pass_cnt++;
      total_cnt++;
      if (rd_addr !== 24'h0) $display("FAIL reset addr got=%h want=000000", rd_addr); else pass_cnt++;
      total_cnt++;
      if (op_done !== 1'b0) $display("FAIL reset done got=%b want=0", op_done); else pass_cnt++;
      rst_ni = 1'b1;
   endtask

   task automatic test_single_alua();
      rd_gnt = 3'b111;
      start_op("single", 2, 0, 3'b001, 40, 1'b0);
      run_checks("single", 4, 3'b000, 0);
   endtask

   task automatic test_stall();
      rd_gnt = 3'b111;
      start_op("stall", 1, 5, 3'b011, 32, 1'b0);
      run_checks("stall", 6, 3'b000, 3);
   endtask

   task automatic test_wrap();
      rd_gnt = 3'b111;
      start_op("wrap", 31, 0, 3'b100, 256, 1'b0);
      run_checks("wrap", 17, 3'b000, 0);
   endtask

   task automatic test_empty();
      rd_gnt = 3'b111;
      start_op("empty_vlb", 3, 4, 3'b111, 0, 1'b0);
      run_checks("empty_vlb", 1, 3'b000, 0);
      start_op("empty_q", 3, 4, 3'b000, 64, 1'b0);
      run_checks("empty_q", 1, 3'b000, 0);
   endtask

   task automatic test_back_to_back();
      rd_gnt = 3'b111;
      start_op("b2b_first", 4, 0, 3'b001, 32, 1'b1);
      op_req = pack_req(0, 7, 3'b010, 20);
      run_checks("b2b_first", 3, 3'b000, 0);
      @(posedge clk);
      load_model(0, 7, 3'b010, 20);
      #1;
      op_req_valid = 1'b0;
      run_checks("b2b_second", 3, 3'b000, 0);
   endtask

   task automatic test_reset_midop();
      rd_gnt = 3'b111;
      start_op("midrst", 3, 0, 3'b001, 64, 1'b0);
      @(negedge clk);
      total_cnt++;
      if (rd_req[0] !== 1'b1 || rd_addr[0] !== 8'd24)
         $display("FAIL midrst first got=%b/%0d want=1/24", rd_req[0], rd_addr[0]);
      else pass_cnt++;
      @(negedge clk);
      rst_ni = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (rd_req !== 3'b000) $display("FAIL midrst req got=%b want=000", rd_req); else pass_cnt++;
      total_cnt++;
      if (op_req_ready !== 1'b1) $display("FAIL midrst ready got=%b want=1", op_req_ready); else pass_cnt++;
      total_cnt++;
      if (op_done !== 1'b0) $display("FAIL midrst done got=%b want=0", op_done); else pass_cnt++;
      rst_ni = 1'b1;
      start_op("after_rst", 3, 0, 3'b001, 64, 1'b0);
      run_checks("after_rst", 5, 3'b000, 0);
   endtask

   task automatic test_random();
      int vs1, vs2, vlb;
      logic [2:0] qr;
      for (int n = 0; n < 25; n++) begin
         vs1 = $urandom_range(0, 31);
         vs2 = $urandom_range(0, 31);
         vlb = $urandom_range(0, 300);
         qr  = 3'($urandom_range(0, 7));
         start_op("random", vs1, vs2, qr, vlb, 1'b0);
         run_checks("random", 0, 3'b111, 0);
      end
   endtask

   initial begin
      rst_ni       = 1'b0;
      op_req_valid = 1'b0;
      op_req       = '0;
      rd_gnt       = '0;
      test_reset();
      test_single_alua();
      test_stall();
      test_wrap();
      test_empty();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
